store_narrow_unit: RTL

- Store-side counterpart of the load-path sign/zero extender in the 31-instruction CPU.
- Narrows a 32-bit register value into a byte, halfword or word store (sb/sh/sw) against a word-wide synchronous data RAM.
- Sub-word stores use read-modify-write, since the RAM has no byte enables by default.
- Sits between the EX/MEM store request and the data RAM. Stalls the pipeline via req_ready.

---
 rtl/store_narrow_unit_if.sv | 38 +++
 rtl/store_narrow_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/store_narrow_unit_if.sv
// Store-request and data-RAM signal bundle for store_narrow_unit.
// mem_be exists only when STORE_BE_EN is defined.
interface store_narrow_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_data;
   logic [1:0]        req_size;
   logic              done;
   logic              err;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [31:0]       mem_rdata;
   logic              mem_wr_en;
   logic [31:0]       mem_wdata;
`ifdef STORE_BE_EN
   logic [3:0]        mem_be;
`endif

   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_rdata,
      output req_ready, done, err, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
`ifdef STORE_BE_EN
      , mem_be
`endif
   );

   modport master (
      output req_valid, req_addr, req_data, req_size, mem_rdata,
      input  req_ready, done, err, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
`ifdef STORE_BE_EN
      , mem_be
`endif
   );
endinterface

// File: rtl/store_narrow_unit.sv
// Narrows sb/sh/sw stores onto a word-wide RAM via read-modify-write.
// Defining STORE_BE_EN switches to single-cycle writes with byte enables (mem_be).
//
// state   | meaning
// --------+--------------------------------------------------------
// st_idle | waiting for a request, req_ready high
// st_rd   | RAM read strobe for the word being modified
// st_wait | counting RD_LAT cycles, rdata captured on the last one
// st_wr   | RAM write strobe, done pulse
// st_err  | misaligned or reserved request, err pulse, no RAM access
module store_narrow_unit #(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input logic                clk,
   input logic                rst_n,
   store_narrow_unit_if.slave bus
);
   localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {
      st_idle,
      st_rd,
      st_wait,
      st_wr,
      st_err
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [1:0]        size_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              accept;
   logic              misaligned;
   logic              cnt_done;
   logic [31:0]       wdata;
`ifndef STORE_BE_EN
   logic [31:0]       rdata_q;
`endif

   assign accept   = bus.req_valid && (state_q == st_idle);
   assign cnt_done = (cnt_q == CNT_W'(RD_LAT));

   always_comb begin
      misaligned = 1'b0;
      case (bus.req_size)
         2'b01:   misaligned = bus.req_addr[0];
         2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= st_idle;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
`ifndef STORE_BE_EN
         rdata_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
            size_q <= bus.req_size;
         end
         if (state_q == st_rd) begin
            cnt_q <= CNT_W'(1);
         end else if ((state_q == st_wait) && !cnt_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
`ifndef STORE_BE_EN
         if ((state_q == st_wait) && cnt_done) begin
            rdata_q <= bus.mem_rdata;
         end
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         st_idle: begin
            if (bus.req_valid) begin
               if (misaligned) begin
                  state_d = st_err;
`ifdef STORE_BE_EN
               end else begin
                  state_d = st_wr;
`else
               end else if (bus.req_size == 2'b10) begin
                  state_d = st_wr;
               end else begin
                  state_d = st_rd;
`endif
               end
            end
         end
         st_rd:   state_d = st_wait;
         st_wait: if (cnt_done) state_d = st_wr;
         st_wr:   state_d = st_idle;
         st_err:  state_d = st_idle;
         default: state_d = st_idle;
      endcase
   end

`ifdef STORE_BE_EN
   // Data is replicated across lanes; mem_be selects which lanes land.
   logic [3:0] be;
   always_comb begin
      wdata = data_q;
      be    = 4'b1111;
      case (size_q)
         2'b00: begin
            wdata = {4{data_q[7:0]}};
            be    = 4'b0001 << addr_q[1:0];
         end
         2'b01: begin
            wdata = {2{data_q[15:0]}};
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata = data_q;
            be    = 4'b1111;
         end
      endcase
   end
   assign bus.mem_be = (state_q == st_wr) ? be : 4'b0000;
`else
   // Little-endian lane merge; upper bits of the register value are dropped.
   always_comb begin
      wdata = data_q;
      case (size_q)
         2'b00: begin
            case (addr_q[1:0])
               2'b00:   wdata = {rdata_q[31:8], data_q[7:0]};
               2'b01:   wdata = {rdata_q[31:16], data_q[7:0], rdata_q[7:0]};
               2'b10:   wdata = {rdata_q[31:24], data_q[7:0], rdata_q[15:0]};
               default: wdata = {data_q[7:0], rdata_q[23:0]};
            endcase
         end
         2'b01:   wdata = addr_q[1] ? {data_q[15:0], rdata_q[15:0]}
                                    : {rdata_q[31:16], data_q[15:0]};
         default: wdata = data_q;
      endcase
   end
`endif

   assign bus.req_ready = (state_q == st_idle);
   assign bus.busy      = (state_q != st_idle);
   assign bus.done      = (state_q == st_wr);
   assign bus.err       = (state_q == st_err);
   assign bus.mem_rd_en = (state_q == st_rd);
   assign bus.mem_wr_en = (state_q == st_wr);
   assign bus.mem_wdata = (state_q == st_wr) ? wdata : 32'h0;
   assign bus.mem_addr  = ((state_q == st_rd) || (state_q == st_wait) || (state_q == st_wr))
                          ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
endmodule
